// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and DM loads/stores onto one single-port memory,
// one transaction at a time, with a starvation guard that eventually forces an IF grant.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_rvalid,
  output logic [DAT_WIDTH-1:0]  o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DAT_WIDTH-1:0]  i_dm_wdata,
  output logic                  o_dm_done,
  output logic [DAT_WIDTH-1:0]  o_dm_rdata,
  output logic                  o_stall_F,
  output logic                  o_stall_M,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DAT_WIDTH-1:0]  o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DAT_WIDTH-1:0]  i_mem_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] L_STARVE_MAX = 4'(STARVE_MAX);
  state_t                r_state;
  logic [3:0]            r_starve;
  logic                  r_owner_dm;
  logic                  r_we;
  logic                  r_mem_req;
  logic                  r_if_rvalid;
  logic                  r_dm_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DAT_WIDTH-1:0]  r_wdata;
  logic [DAT_WIDTH-1:0]  r_if_rdata;
  logic [DAT_WIDTH-1:0]  r_dm_rdata;
  logic                  w_idle;
  logic                  w_grant_if;
  logic                  w_grant_dm;
  logic                  w_ack;
  assign w_idle     = (r_state == IDLE);
  assign w_grant_if = w_idle & i_if_req & (~i_dm_req | (r_starve == L_STARVE_MAX));
  assign w_grant_dm = w_idle & i_dm_req & ~w_grant_if;
  assign w_ack      = ~w_idle & i_mem_ack;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_owner_dm  <= 1'b0;
      r_we        <= 1'b0;
      r_mem_req   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_done   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_ack & ~r_owner_dm;
      r_if_rdata  <= (w_ack & ~r_owner_dm) ? i_mem_rdata : '0;
      r_dm_done   <= w_ack & r_owner_dm;
      r_dm_rdata  <= (w_ack & r_owner_dm & ~r_we) ? i_mem_rdata : '0;
      if (w_idle) begin
        if (~i_if_req | w_grant_if) r_starve <= '0;
        else if (w_grant_dm & (r_starve != L_STARVE_MAX)) r_starve <= r_starve + 4'd1;
        if (w_grant_if | w_grant_dm) begin
          r_state    <= BUSY;
          r_mem_req  <= 1'b1;
          r_owner_dm <= w_grant_dm;
          r_we       <= w_grant_dm & i_dm_we;
          r_addr     <= w_grant_dm ? i_dm_addr : i_if_addr;
          r_wdata    <= w_grant_dm ? i_dm_wdata : '0;
        end
      end else if (i_mem_ack) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
      end
    end
  end
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_done   = r_dm_done;
  assign o_dm_rdata  = r_dm_rdata;
  // gated by rst_n so every output reads 0 while reset is held
  assign o_stall_F   = rst_n & i_if_req & ~r_if_rvalid;
  assign o_stall_M   = rst_n & i_dm_req & ~r_dm_done;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a
// golden memory image and the starvation rule, with a latency-randomized memory slave.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          o_dm_done;
  logic [DW-1:0] o_dm_rdata;
  logic          o_stall_F;
  logic          o_stall_M;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          mem_ack;
  logic          s_ack = 1'b0;
  logic          spur = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  int vec = 0;
  int errs = 0;
  int lat_lo = 1;
  int lat_hi = 3;
  bit slave_en = 1'b1;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] gmem [logic [31:0]];

  assign mem_ack = s_ack | spur;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DAT_WIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_done(o_dm_done), .o_dm_rdata(o_dm_rdata),
    .o_stall_F(o_stall_F), .o_stall_M(o_stall_M),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] sread(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] gread(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : dflt(a);
  endfunction

  // memory slave: acks lat cycles after it first sees mem_req, lat in [lat_lo, lat_hi]
  initial begin
    int wcnt = 0;
    int lat = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        s_ack = 1'b0;
        wcnt = 0;
      end else if (!slave_en) wcnt = 0;
      else if (s_ack) s_ack = 1'b0;
      else if (o_mem_req) begin
        wcnt++;
        if (wcnt == 1) lat = $urandom_range(lat_hi, lat_lo);
        if (wcnt > lat) begin
          s_ack = 1'b1;
          wcnt = 0;
          if (o_mem_we) begin
            smem[o_mem_addr] = o_mem_wdata;
            mem_rdata = $urandom;
          end else mem_rdata = sread(o_mem_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({o_if_rvalid, o_dm_done, o_stall_F, o_stall_M, o_mem_req, o_mem_we} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 000000", {o_if_rvalid, o_dm_done, o_stall_F, o_stall_M, o_mem_req, o_mem_we});
    end
    vec++;
    if ({o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata} !== 128'h0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0", {o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata});
    end
    if_req = 1'b1;
    dm_req = 1'b1;
    #1;
    vec++;
    if ({o_stall_F, o_stall_M} !== 2'b00) begin
      errs++;
      $display("FAIL reset_stall: got %b want 00", {o_stall_F, o_stall_M});
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    int rise = -1;
    bit done = 1'b0;
    smem[32'h10] = 32'h0050_0093;
    gmem[32'h10] = 32'h0050_0093;
    lat_lo = 2;
    lat_hi = 2;
    if_addr = 32'h10;
    if_req = 1'b1;
    for (int c = 1; c <= 30 && !done; c++) begin
      tick();
      vec++;
      if (o_stall_F !== ~o_if_rvalid) begin
        errs++;
        $display("FAIL if_read_stall: cycle %0d got %b want %b", c, o_stall_F, ~o_if_rvalid);
      end
      if (o_mem_req && rise < 0) begin
        rise = c;
        vec++;
        if (o_mem_addr !== 32'h10 || o_mem_we !== 1'b0) begin
          errs++;
          $display("FAIL if_read_cmd: got addr %h we %b want 00000010 we 0", o_mem_addr, o_mem_we);
        end
      end
      if (o_if_rvalid) begin
        done = 1'b1;
        if_req = 1'b0;
        vec++;
        if (o_if_rdata !== 32'h0050_0093) begin
          errs++;
          $display("FAIL if_read_data: got %h want 00500093", o_if_rdata);
        end
        vec++;
        if (c - rise != 3) begin
          errs++;
          $display("FAIL if_read_latency: got %0d want 3", c - rise);
        end
      end
    end
    vec++;
    if (!done) begin
      errs++;
      $display("FAIL if_read_timeout: got no if_rvalid want one");
    end
    repeat (3) begin
      tick();
      vec++;
      if ({o_if_rvalid, o_mem_req} !== 2'b00) begin
        errs++;
        $display("FAIL if_read_quiet: got %b want 00", {o_if_rvalid, o_mem_req});
      end
    end
  endtask

  task automatic test_dm_store_load();
    bit done;
    bit we;
    lat_lo = 1;
    lat_hi = 1;
    for (int op = 0; op < 2; op++) begin
      we = (op == 0);
      done = 1'b0;
      dm_we = we;
      dm_addr = 32'h100;
      dm_wdata = 32'hDEAD_BEEF;
      dm_req = 1'b1;
      for (int c = 0; c < 30 && !done; c++) begin
        tick();
        if (o_mem_req) begin
          vec++;
          if (o_mem_we !== we || o_mem_addr !== 32'h100 || (we && o_mem_wdata !== 32'hDEAD_BEEF)) begin
            errs++;
            $display("FAIL dm_cmd: got we %b addr %h wdata %h want we %b addr 00000100 wdata deadbeef",
                     o_mem_we, o_mem_addr, o_mem_wdata, we);
          end
          dm_addr = 32'h0BAD_0000;
          dm_wdata = 32'h1234_5678;
        end
        if (o_dm_done) begin
          done = 1'b1;
          vec++;
          if (o_dm_rdata !== (we ? 32'h0 : gread(32'h100))) begin
            errs++;
            $display("FAIL dm_rdata: op %0d got %h want %h", op, o_dm_rdata, we ? 32'h0 : gread(32'h100));
          end
          vec++;
          if (o_stall_M !== 1'b0) begin
            errs++;
            $display("FAIL dm_stall: got %b want 0", o_stall_M);
          end
          if (we) gmem[32'h100] = 32'hDEAD_BEEF;
          dm_req = 1'b0;
        end
      end
      vec++;
      if (!done) begin
        errs++;
        $display("FAIL dm_timeout: op %0d got no dm_done want one", op);
      end
    end
    tick();
  endtask

  task automatic test_starve();
    int n = 0;
    int t = 0;
    bit prev = 1'b0;
    bit exp_if;
    lat_lo = 1;
    lat_hi = 3;
    if_addr = 32'h40;
    dm_we = 1'b0;
    dm_addr = 32'h80;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int c = 0; c < 600 && n < 15; c++) begin
      tick();
      if (o_mem_req && !prev) begin
        exp_if = (t % (SM + 1)) == SM;
        vec++;
        if (o_mem_addr !== (exp_if ? 32'h40 : 32'h80)) begin
          errs++;
          $display("FAIL starve_grant: grant %0d got addr %h want %h", t, o_mem_addr, exp_if ? 32'h40 : 32'h80);
        end
        t++;
      end
      prev = o_mem_req;
      if (o_if_rvalid || o_dm_done) begin
        exp_if = (n % (SM + 1)) == SM;
        vec++;
        if ({o_if_rvalid, o_dm_done} !== (exp_if ? 2'b10 : 2'b01)) begin
          errs++;
          $display("FAIL starve_order: completion %0d got %b want %b", n, {o_if_rvalid, o_dm_done}, exp_if ? 2'b10 : 2'b01);
        end
        n++;
        if (n == 15) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
    end
    vec++;
    if (n != 15) begin
      errs++;
      $display("FAIL starve_timeout: got %0d completions want 15", n);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_abandon();
    int rises = 0;
    int ifp = 0;
    bit prev = 1'b0;
    bit done = 1'b0;
    lat_lo = 2;
    lat_hi = 3;
    if_addr = 32'h20;
    if_req = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!if_req) begin
        vec++;
        if (o_stall_F !== 1'b0) begin
          errs++;
          $display("FAIL abandon_stall: got %b want 0", o_stall_F);
        end
      end
      if (o_mem_req && !prev) begin
        rises++;
        vec++;
        if (o_mem_addr !== (rises == 1 ? 32'h20 : 32'h84) || o_mem_we !== 1'b0) begin
          errs++;
          $display("FAIL abandon_grant: grant %0d got addr %h we %b want %h we 0",
                   rises, o_mem_addr, o_mem_we, rises == 1 ? 32'h20 : 32'h84);
        end
      end
      prev = o_mem_req;
      if (rises == 1 && if_req) begin
        if_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = 32'h84;
        dm_req = 1'b1;
      end
      if (o_if_rvalid) begin
        ifp++;
        vec++;
        if (o_if_rdata !== gread(32'h20)) begin
          errs++;
          $display("FAIL abandon_if_data: got %h want %h", o_if_rdata, gread(32'h20));
        end
      end
      if (o_dm_done) begin
        done = 1'b1;
        dm_req = 1'b0;
        vec++;
        if (o_dm_rdata !== gread(32'h84)) begin
          errs++;
          $display("FAIL abandon_dm_data: got %h want %h", o_dm_rdata, gread(32'h84));
        end
      end
    end
    vec++;
    if (!done || ifp != 1) begin
      errs++;
      $display("FAIL abandon_count: got dm_done %0d if_rvalid %0d want 1 1", done, ifp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit done = 1'b0;
    int ifp = 0;
    lat_lo = 3;
    lat_hi = 3;
    if_addr = 32'h24;
    if_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h88;
    dm_req = 1'b1;
    for (int c = 0; c < 10 && !o_mem_req; c++) tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({o_mem_req, o_stall_F, o_stall_M, o_if_rvalid, o_dm_done} !== 5'b0) begin
      errs++;
      $display("FAIL reset_mid_async: got %b want 00000", {o_mem_req, o_stall_F, o_stall_M, o_if_rvalid, o_dm_done});
    end
    tick();
    if_req = 1'b0;
    vec++;
    if ({o_mem_req, o_mem_we, o_mem_addr} !== 34'h0) begin
      errs++;
      $display("FAIL reset_mid_hold: got %h want 0", {o_mem_req, o_mem_we, o_mem_addr});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (o_if_rvalid) ifp++;
      if (o_dm_done) begin
        done = 1'b1;
        dm_req = 1'b0;
        vec++;
        if (o_dm_rdata !== gread(32'h88)) begin
          errs++;
          $display("FAIL reset_mid_data: got %h want %h", o_dm_rdata, gread(32'h88));
        end
      end
    end
    vec++;
    if (!done || ifp != 0) begin
      errs++;
      $display("FAIL reset_mid_after: got dm_done %0d if_rvalid %0d want 1 0", done, ifp);
    end
    tick();
  endtask

  task automatic test_spurious();
    bit done = 1'b0;
    slave_en = 1'b0;
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) begin
      tick();
      vec++;
      if ({o_if_rvalid, o_dm_done, o_mem_req} !== 3'b000) begin
        errs++;
        $display("FAIL spurious_ack: got %b want 000", {o_if_rvalid, o_dm_done, o_mem_req});
      end
    end
    slave_en = 1'b1;
    lat_lo = 1;
    lat_hi = 2;
    if_addr = 32'h28;
    if_req = 1'b1;
    tick();
    vec++;
    if (o_mem_req !== 1'b1) begin
      errs++;
      $display("FAIL spurious_grant: got mem_req %b want 1", o_mem_req);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (o_if_rvalid) begin
        done = 1'b1;
        if_req = 1'b0;
        vec++;
        if (o_if_rdata !== gread(32'h28)) begin
          errs++;
          $display("FAIL spurious_read: got %h want %h", o_if_rdata, gread(32'h28));
        end
      end
    end
    vec++;
    if (!done) begin
      errs++;
      $display("FAIL spurious_timeout: got no if_rvalid want one");
    end
    tick();
  endtask

  task automatic test_random();
    bit ip = 1'b0;
    bit dp = 1'b0;
    bit dwe = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    logic [31:0] dw = '0;
    logic [31:0] exp;
    int done_n = 0;
    int ifw = 0;
    int dmw = 0;
    int dm_during = 0;
    lat_lo = 1;
    lat_hi = 3;
    for (int c = 0; c < 8000; c++) begin
      tick();
      vec++;
      if (o_stall_F !== (ip & ~o_if_rvalid) || o_stall_M !== (dp & ~o_dm_done)) begin
        errs++;
        $display("FAIL rnd_stall: cycle %0d got %b want %b", c, {o_stall_F, o_stall_M}, {ip & ~o_if_rvalid, dp & ~o_dm_done});
      end
      if (o_if_rvalid) begin
        vec++;
        if (!ip || o_if_rdata !== gread(ia)) begin
          errs++;
          $display("FAIL rnd_if: pending %b addr %h got %h want %h", ip, ia, o_if_rdata, gread(ia));
        end
        ip = 1'b0;
        if_req = 1'b0;
        dm_during = 0;
        done_n++;
      end
      if (o_dm_done) begin
        exp = dwe ? 32'h0 : gread(da);
        vec++;
        if (!dp || o_dm_rdata !== exp) begin
          errs++;
          $display("FAIL rnd_dm: pending %b we %b addr %h got %h want %h", dp, dwe, da, o_dm_rdata, exp);
        end
        if (dwe) gmem[da] = dw;
        dp = 1'b0;
        dm_req = 1'b0;
        done_n++;
        if (ip) begin
          dm_during++;
          vec++;
          if (dm_during > SM + 1) begin
            errs++;
            $display("FAIL rnd_starve: got %0d dm completions while if waits want <= %0d", dm_during, SM + 1);
          end
        end
      end
      ifw = ip ? ifw + 1 : 0;
      dmw = dp ? dmw + 1 : 0;
      if (ifw > 200 || dmw > 200) begin
        errs++;
        $display("FAIL rnd_timeout: got wait if %0d dm %0d want <= 200", ifw, dmw);
        break;
      end
      if (done_n < 300) begin
        if (!ip && $urandom_range(2, 0) == 0) begin
          ip = 1'b1;
          ia = 32'h200 + 32'($urandom_range(7, 0) * 4);
          if_addr = ia;
          if_req = 1'b1;
        end
        if (!dp && $urandom_range(2, 0) == 0) begin
          dp = 1'b1;
          da = 32'h200 + 32'($urandom_range(7, 0) * 4);
          dwe = 1'($urandom_range(1, 0));
          dw = $urandom;
          dm_we = dwe;
          dm_addr = da;
          dm_wdata = dw;
          dm_req = 1'b1;
        end
      end else if (!ip && !dp) break;
    end
    vec++;
    if (done_n < 300 || ip || dp) begin
      errs++;
      $display("FAIL rnd_incomplete: got %0d completions pending %b%b want >= 300 and none pending", done_n, ip, dp);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store_load();
    test_starve();
    test_abandon();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch-stage instruction requester (IF) and the memory-stage data requester (DM).
- Sits between the Fetch/Memory stages and the memory model.
- Serialises accesses with one outstanding transaction and returns responses to the owning requester.
- Drives per-requester stall outputs that the hazard logic uses to freeze the pipeline.

Parameters:
- ADDR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width.
- STARVE_MAX, 4, consecutive DM grants made while IF waits before IF is forced to win (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF read request; held until if_rvalid
- if_addr  in  ADDR_WIDTH  IF address
- if_rvalid  out  1  IF read data valid, 1-cycle pulse
- if_rdata  out  DAT_WIDTH  IF read data
- dm_req  in  1  DM request; held until dm_done
- dm_we  in  1  DM write enable (1 = store, 0 = load)
- dm_addr  in  ADDR_WIDTH  DM address
- dm_wdata  in  DAT_WIDTH  DM store data
- dm_done  out  1  DM completion, 1-cycle pulse (loads and stores)
- dm_rdata  out  DAT_WIDTH  DM load data, valid with dm_done
- stall_F  out  1  IF request pending and not completing this cycle
- stall_M  out  1  DM request pending and not completing this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DAT_WIDTH  memory write data
- mem_ack  in  1  memory completion, 1-cycle pulse, at least 1 cycle after mem_req rises
- mem_rdata  in  DAT_WIDTH  memory read data, valid with mem_ack

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; starve counter 0; owner register = IF.
- FSM states: IDLE, BUSY.
- IDLE with no request: stay in IDLE, mem_req = 0.
- IDLE with any request: grant one requester, latch its command (addr, we, wdata, owner) into registers, go to BUSY.
- mem_* outputs are driven from those registers only, so they are registered and stable for the whole transaction.
- BUSY: mem_req = 1; wait for mem_ack.
- On mem_ack in BUSY:
  - Owner IF: pulse if_rvalid with if_rdata = mem_rdata.
  - Owner DM: pulse dm_done; dm_rdata = mem_rdata for loads, 0 for stores.
  - Return to IDLE.
- Minimum turnaround: one IDLE cycle between transactions, so back-to-back accesses take at least 3 cycles each.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: DM wins unless starve counter == STARVE_MAX, in which case IF wins.
- Starve counter:
  - Increments on each DM grant made while if_req = 1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Clears when if_req = 0 in IDLE.
- Stall outputs:
  - stall_F = if_req & ~if_rvalid.
  - stall_M = dm_req & ~dm_done.
  - Both are combinational from the registered pulses; no dependency on mem_ack.
- Requester side:
  - Request inputs are sampled only in IDLE.
  - Changes to addr/wdata during BUSY are ignored.
  - A requester dropping req during BUSY (e.g. IF flushed by a branch) does not abort: the memory access completes, the response pulse is still issued, and the consumer discards it.
- mem_ack outside BUSY: ignored, no state change.
- Reset asserted mid-transaction: immediately returns to IDLE with all outputs 0; any in-flight response is lost; the memory is reset by the same rst_n.
- No address or width arithmetic: addresses pass through unmodified.
- Implementation sizing: 150-250 lines of RTL.

Test Plan:
- IF-only read: if_req = 1, if_addr = 0x0000_0010, memory acks 2 cycles after mem_req with 0x0050_0093 -> mem_addr = 0x10, mem_we = 0, if_rvalid pulses once with if_rdata = 0x0050_0093, stall_F high until that cycle.
- DM store: dm_req = 1, dm_we = 1, dm_addr = 0x100, dm_wdata = 0xDEAD_BEEF, ack after 1 cycle -> mem_we = 1, mem_wdata = 0xDEAD_BEEF, dm_done pulse, dm_rdata = 0.
- Simultaneous requests, STARVE_MAX = 4: if_req and dm_req held high continuously -> grant order DM, DM, DM, DM, IF, then DM×4, IF repeating; if_rvalid every 5th completion.
- Abandoned fetch: IF granted, if_req drops in BUSY -> mem access completes, if_rvalid still pulses once, next IDLE grants DM if requested.
- Reset mid-BUSY: assert rst_n = 0 while mem_req = 1 -> mem_req, stall_F, stall_M, if_rvalid, dm_done = 0 asynchronously; after release, new request is served normally.
- Spurious ack: mem_ack = 1 in IDLE with no request -> no if_rvalid/dm_done, FSM stays IDLE.
